// File: rtl/dff_bank_rr_arbiter_pkg.sv
// Shared types for the round-robin arbitrated register bank.
// Op encodings, FSM states and a counter-width helper.
package dff_arb_pkg;

   typedef enum logic [1:0] {
      OP_LOAD = 2'b00,
      OP_SET  = 2'b01,
      OP_CLR  = 2'b10,
      OP_HOLD = 2'b11
   } op_e;

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } state_e;

   // Width of the ownership counter; never below one bit.
   function automatic int hold_w(input int max_hold);
      int w;
      w = $clog2(max_hold + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/dff_bank_rr_arbiter_if.sv
// Requester-side bus of the arbitrated register bank.
// Master drives requests/ops/data, slave returns grant and Q.
interface dff_bank_rr_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 8
);

   logic [NUM_REQ-1:0]       req;
   logic [2*NUM_REQ-1:0]     op;
   logic [WIDTH*NUM_REQ-1:0] wdata;
   logic [NUM_REQ-1:0]       gnt;
   logic [WIDTH-1:0]         Q;
   logic                     upd;
   logic                     timeout;

   modport master (
      output req, op, wdata,
      input  gnt, Q, upd, timeout
   );

   modport slave (
      input  req, op, wdata,
      output gnt, Q, upd, timeout
   );

endinterface

// File: rtl/dff_bank_rr_arbiter_pick.sv
// Combinational round-robin picker.
// First set request at or after ptr, wrapping modulo N.
module rr_arbiter_pick #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);

   // Scan from farthest to nearest so the nearest hit wins.
   always_comb begin
      logic [IW:0] c;
      idx_o = '0;
      any_o = |req_i;
      c     = '0;
      for (int k = N - 1; k >= 0; k--) begin
         c = {1'b0, ptr_i} + (IW+1)'(k);
         if (c >= (IW+1)'(N)) begin
            c = c - (IW+1)'(N);
         end
         if (req_i[c[IW-1:0]]) begin
            idx_o = c[IW-1:0];
         end
      end
      gnt_o = any_o ? (N'(1) << idx_o) : '0;
   end

endmodule

// File: rtl/dff_bank_rr_arbiter.sv
// Register bank shared by NUM_REQ requesters under round-robin
// ownership with a bounded hold time.
module dff_bank_rr_arbiter
   import dff_arb_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int WIDTH    = 8,
   parameter int MAX_HOLD = 16
) (
   input  logic            clk,
   input  logic            reset,
   dff_bank_rr_arbiter_if.slave bus
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int HW = hold_w(MAX_HOLD);
   localparam int HL = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

   state_e             state_q;
   logic [NUM_REQ-1:0] gnt_q;
   logic [WIDTH-1:0]   q_q;
   logic               upd_q;
   logic               to_q;
   logic [IW-1:0]      ptr_q;
   logic [IW-1:0]      own_q;
   logic [NUM_REQ-1:0] mask_q;
   logic [HW-1:0]      cnt_q;

   logic [NUM_REQ-1:0] req_eff;
   logic [NUM_REQ-1:0] pick_req;
   logic [NUM_REQ-1:0] pick_gnt;
   logic [IW-1:0]      pick_idx;
   logic               pick_any;

   logic               own_req;
   op_e                own_op;
   logic [WIDTH-1:0]   own_wd;
   logic [WIDTH-1:0]   q_d;
   logic [IW-1:0]      ptr_d;
   logic               hold_last;

   // A masked requester is still eligible when nobody else asks.
   assign req_eff  = bus.req & ~mask_q;
   assign pick_req = (|req_eff) ? req_eff : bus.req;

   rr_arbiter_pick #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_pick (
      .req_i (pick_req),
      .ptr_i (ptr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

   assign own_req = bus.req[own_q];
   assign own_op  = op_e'(bus.op[2*own_q +: 2]);
   assign own_wd  = bus.wdata[WIDTH*own_q +: WIDTH];

   assign ptr_d = (own_q == IW'(NUM_REQ - 1)) ? '0 : own_q + 1'b1;

   assign hold_last = (MAX_HOLD != 0) && (cnt_q == HW'(HL));

   // Value the owner's op would write into the bank.
   always_comb begin
      q_d = q_q;
      unique case (own_op)
         OP_LOAD: q_d = own_wd;
         OP_SET:  q_d = '1;
         OP_CLR:  q_d = '0;
         OP_HOLD: q_d = q_q;
         default: q_d = q_q;
      endcase
   end

   // Ownership FSM with the bank and all registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         q_q     <= '0;
         upd_q   <= 1'b0;
         to_q    <= 1'b0;
         ptr_q   <= '0;
         own_q   <= '0;
         mask_q  <= '0;
         cnt_q   <= '0;
      end else begin
         upd_q <= 1'b0;
         to_q  <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (pick_any) begin
                  state_q <= OWN;
                  gnt_q   <= pick_gnt;
                  own_q   <= pick_idx;
                  mask_q  <= '0;
                  cnt_q   <= '0;
               end
            end
            OWN: begin
               if (!own_req) begin
                  state_q <= IDLE;
                  gnt_q   <= '0;
                  ptr_q   <= ptr_d;
               end else begin
                  q_q   <= q_d;
                  upd_q <= (own_op != OP_HOLD);
                  if (cnt_q != '1) begin
                     cnt_q <= cnt_q + 1'b1;
                  end
                  if (hold_last) begin
                     state_q       <= IDLE;
                     gnt_q         <= '0;
                     to_q          <= 1'b1;
                     ptr_q         <= ptr_d;
                     mask_q[own_q] <= 1'b1;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               gnt_q   <= '0;
            end
         endcase
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.Q       = q_q;
   assign bus.upd     = upd_q;
   assign bus.timeout = to_q;

   a_gnt_onehot: assert property (
      @(posedge clk) disable iff (!reset) $onehot0(gnt_q)
   );

endmodule
